div_16x8_seq: RTL and testbench



---
 rtl/div_pkg.sv | 34 +++
 rtl/div_step.sv | 30 +++
 rtl/div_16x8_seq.sv | 143 ++++++++++++++
 tb/tb_div_16x8_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants, state encoding and helpers for the sequential 16/8 divider.
// DIV_SATURATE_EN selects an all-ones quotient on overflow instead of zero.
package div_pkg;

    localparam int W_Q   = 8;
    localparam int W_A   = 2 * W_Q;
    localparam int ITER  = W_Q;
    localparam int W_CNT = $clog2(ITER);

    localparam logic [W_CNT-1:0] CNT_ZERO = {W_CNT{1'b0}};
    localparam logic [W_CNT-1:0] CNT_ONE  = {{(W_CNT-1){1'b0}}, 1'b1};
    localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(ITER - 1);

    localparam logic [W_Q-1:0] ZERO_W = {W_Q{1'b0}};

`ifdef DIV_SATURATE_EN
    localparam logic [W_Q-1:0] OVF_Q_VAL = {W_Q{1'b1}};
`else
    localparam logic [W_Q-1:0] OVF_Q_VAL = {W_Q{1'b0}};
`endif
    localparam logic [W_Q-1:0] OVF_R_VAL = {W_Q{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The quotient fits in W_Q bits only when the upper dividend half is below the divisor.
    function automatic logic is_overflow(input logic [W_Q-1:0] a_hi, input logic [W_Q-1:0] b);
        return (b == ZERO_W) || (a_hi >= b);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in the next dividend bit and
// subtract the divisor when the partial remainder allows it.
module div_step
    import div_pkg::*;
(
    input  logic [W_Q-1:0] rem_i,
    input  logic           din_i,
    input  logic [W_Q-1:0] b_i,
    output logic [W_Q-1:0] rem_next_o,
    output logic           qbit_o
);

    logic [W_Q:0] t_s;

    assign t_s = {rem_i, din_i};

    // Restoring compare/subtract; rem_i < b_i keeps the difference inside W_Q bits.
    always_comb begin
        rem_next_o = t_s[W_Q-1:0];
        qbit_o     = 1'b0;
        if (t_s >= {1'b0, b_i}) begin
            rem_next_o = t_s[W_Q-1:0] - b_i;
            qbit_o     = 1'b1;
        end else begin
            rem_next_o = t_s[W_Q-1:0];
            qbit_o     = 1'b0;
        end
    end

endmodule

// File: rtl/div_16x8_seq.sv
// Sequential radix-2 restoring divider, 16-bit / 8-bit, one quotient bit per clock.
// Overflow result values depend on DIV_SATURATE_EN (see div_pkg).
module div_16x8_seq
    import div_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W_A-1:0] A,
    input  logic [W_Q-1:0] B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W_Q-1:0] Q,
    output logic [W_Q-1:0] R,
    output logic           ovf
);

    state_e           state_q, state_d;
    logic [W_Q-1:0]   b_q, b_d;
    logic [W_Q-1:0]   rem_q, rem_d;
    logic [W_Q-1:0]   qsh_q, qsh_d;
    logic [W_CNT-1:0] cnt_q, cnt_d;
    logic [W_Q-1:0]   quo_q, quo_d;
    logic [W_Q-1:0]   rmd_q, rmd_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [W_Q-1:0]   step_rem_s;
    logic             step_qbit_s;

    div_step u_step (
        .rem_i      (rem_q),
        .din_i      (qsh_q[W_Q-1]),
        .b_i        (b_q),
        .rem_next_o (step_rem_s),
        .qbit_o     (step_qbit_s)
    );

    // Next-state and datapath control for the IDLE/CALC/DONE sequence.
    always_comb begin
        state_d     = state_q;
        b_d         = b_q;
        rem_d       = rem_q;
        qsh_d       = qsh_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rmd_d       = rmd_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    b_d        = B;
                    in_ready_d = 1'b0;
                    if (is_overflow(A[W_A-1:W_Q], B)) begin
                        ovf_d       = 1'b1;
                        quo_d       = OVF_Q_VAL;
                        rmd_d       = OVF_R_VAL;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        ovf_d   = 1'b0;
                        rem_d   = A[W_A-1:W_Q];
                        qsh_d   = A[W_Q-1:0];
                        cnt_d   = CNT_ZERO;
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CALC: begin
                rem_d = step_rem_s;
                qsh_d = {qsh_q[W_Q-2:0], step_qbit_s};
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    quo_d       = {qsh_q[W_Q-2:0], step_qbit_s};
                    rmd_d       = step_rem_s;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_CALC;
                end
            end

            ST_DONE: begin
                // Returning to IDLE here, not accepting, gives the one-cycle gap between operations.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            b_q         <= ZERO_W;
            rem_q       <= ZERO_W;
            qsh_q       <= ZERO_W;
            cnt_q       <= CNT_ZERO;
            quo_q       <= ZERO_W;
            rmd_q       <= ZERO_W;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            b_q         <= b_d;
            rem_q       <= rem_d;
            qsh_q       <= qsh_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rmd_q       <= rmd_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Q         = quo_q;
    assign R         = rmd_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_div_16x8_seq.sv
// Scoreboard bench for div_16x8_seq: directed corner cases followed by random
// back-to-back operations with random output stalls, checked against A/B and A%B.
module tb_div_16x8_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [7:0]  B;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  Q;
    logic [7:0]  R;
    logic        ovf;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       ovf;
    } exp_t;

`ifdef DIV_SATURATE_EN
    localparam logic [7:0] OVF_Q = 8'hFF;
`else
    localparam logic [7:0] OVF_Q = 8'h00;
`endif

    exp_t sb_q[$];
    int   n_vec     = 0;
    int   n_err     = 0;
    int   n_issued  = 0;
    int   n_results = 0;
    bit   rand_rdy  = 1'b0;

    always #5 clk = ~clk;

    div_16x8_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .ovf       (ovf)
    );

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        if (b == 0 || (a / b) > 255) begin
            e.q   = OVF_Q;
            e.r   = 8'h00;
            e.ovf = 1'b1;
        end else begin
            e.q   = 8'(a / b);
            e.r   = 8'(a % b);
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [7:0] b);
        A        = a;
        B        = b;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (in_ready === 1'b1) begin
                @(posedge clk);
                sb_q.push_back(model(int'(a), int'(b)));
                n_issued++;
                #1;
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        in_valid = 1'b0;
        n_vec++;
        n_err++;
        $display("FAIL issue_timeout: in_ready never seen for A=%h B=%h", a, b);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            if (in_ready === 1'b1 && out_valid === 1'b0) return;
            tick();
        end
        n_vec++;
        n_err++;
        $display("FAIL %s: block did not return to idle within 300 cycles", name);
    endtask

    // Monitor: a result is taken at the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_results++;
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result: got Q=%h R=%h ovf=%b, expected no result", Q, R, ovf);
            end else begin
                e = sb_q.pop_front();
                if ({Q, R, ovf} !== e) begin
                    n_err++;
                    $display("FAIL result: got Q=%h R=%h ovf=%b, expected Q=%h R=%h ovf=%b",
                             Q, R, ovf, e.q, e.r, e.ovf);
                end
            end
        end
    end

    // Random output back-pressure while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [7:0]  rb;
        logic [7:0]  ahi;
        logic [7:0]  alo;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = 16'h0000;
        B         = 8'h00;
        tick();
        tick();
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_Q",         32'(Q),         32'd0);
        chk("rst_R",         32'(R),         32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        rst = 1'b0;
        tick();

        // 1000 / 7 with exact latency check.
        out_ready = 1'b1;
        issue(16'h03E8, 8'h07);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) chk("lat_norm_before", 32'(out_valid), 32'd0);
            if (k == 8) chk("lat_norm_at8",    32'(out_valid), 32'd1);
        end
        wait_idle("idle_after_1000_7");

        // Largest quotient that still fits.
        issue(16'h7FFF, 8'h80);
        wait_idle("idle_after_7fff_80");

        // Overflow and divide-by-zero, held so the early result can be inspected.
        out_ready = 1'b0;
        issue(16'hFFFE, 8'hFF);
        tick();
        chk("ovf1_valid", 32'(out_valid), 32'd1);
        chk("ovf1_flag",  32'(ovf),       32'd1);
        chk("ovf1_Q",     32'(Q),         32'(OVF_Q));
        chk("ovf1_R",     32'(R),         32'd0);
        out_ready = 1'b1;
        wait_idle("idle_after_ovf1");
        out_ready = 1'b0;
        issue(16'h1234, 8'h00);
        tick();
        chk("dz_valid", 32'(out_valid), 32'd1);
        chk("dz_flag",  32'(ovf),       32'd1);
        chk("dz_Q",     32'(Q),         32'(OVF_Q));
        chk("dz_R",     32'(R),         32'd0);
        out_ready = 1'b1;
        wait_idle("idle_after_dz");

        // Output stall: result must stay stable and no new input accepted.
        out_ready = 1'b0;
        issue(16'h00FF, 8'h01);
        for (int i = 0; i < 30 && out_valid !== 1'b1; i++) tick();
        chk("hold_reached", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_Q",        32'(Q),         32'hFF);
            chk("hold_R",        32'(R),         32'h00);
            chk("hold_valid",    32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("release_in_ready",  32'(in_ready),  32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of CALC discards the operation.
        issue(16'h5555, 8'hC3);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb_q.pop_back());
        n_issued--;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        issue(16'h0064, 8'h0A);
        wait_idle("idle_after_abort");

        // Random back-to-back non-overflow operations under random stalls.
        rand_rdy = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            rb  = 8'($urandom_range(1, 255));
            ahi = 8'($urandom_range(0, int'(rb) - 1));
            alo = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) tick();
            issue({ahi, alo}, rb);
        end
        rand_rdy  = 1'b0;
        #2;
        out_ready = 1'b1;
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) tick();
        chk("sb_drained",   32'(sb_q.size()), 32'd0);
        chk("result_count", 32'(n_results),   32'(n_issued));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
